// File: rtl/date_offset_sched.sv
// Round-robin scheduler for two calendar query sources. Each query is stepped
// one day per cycle to produce the days N before and N after today.
module date_offset_sched #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [4:0] req0_today,
    input  logic       req0_day30_31,
    input  logic [2:0] req0_n,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [4:0] req1_today,
    input  logic       req1_day30_31,
    input  logic [2:0] req1_n,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [4:0] rsp_dbn,
    output logic [4:0] rsp_dan,
    output logic       rsp_error,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic       id_q, id_d;
    logic [4:0] today_q, today_d;
    logic [4:0] len_q, len_d;
    logic [2:0] n_q, n_d;
    logic [2:0] cnt_q, cnt_d;
    logic [4:0] dbn_q, dbn_d;
    logic [4:0] dan_q, dan_d;
    logic       err_q, err_d;
    logic       grant0, grant1;

    // rr_q == 0 favours requester 0 when both are valid
    assign grant0 = req0_valid && (!req1_valid || !rr_q);
    assign grant1 = req1_valid && (!req0_valid || rr_q);

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        id_d       = id_q;
        today_d    = today_q;
        len_d      = len_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        dbn_d      = dbn_q;
        dan_d      = dan_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant0 && !rst;
                req1_ready = grant1 && !rst;
                if (grant0) begin
                    id_d    = 1'b0;
                    today_d = req0_today;
                    len_d   = req0_day30_31 ? 5'd31 : 5'd30;
                    n_d     = req0_n;
                    rr_d    = 1'b1;
                    state_d = CHECK;
                end else if (grant1) begin
                    id_d    = 1'b1;
                    today_d = req1_today;
                    len_d   = req1_day30_31 ? 5'd31 : 5'd30;
                    n_d     = req1_n;
                    rr_d    = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (today_q == 5'd0 || today_q > len_q) begin
                    err_d   = 1'b1;
                    dbn_d   = '0;
                    dan_d   = '0;
                    state_d = DONE;
                end else begin
                    err_d = 1'b0;
                    dbn_d = today_q;
                    dan_d = today_q;
                    cnt_d = n_q;
                    state_d = (n_q == 3'd0) ? DONE : STEP;
                end
            end
            STEP: begin
                dbn_d = (dbn_q == 5'd1) ? len_q : dbn_q - 5'd1;
                dan_d = (dan_q == len_q) ? 5'd1 : dan_q + 5'd1;
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= RR_INIT;
            id_q    <= 1'b0;
            today_q <= '0;
            len_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            dbn_q   <= '0;
            dan_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            today_q <= today_d;
            len_q   <= len_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            dbn_q   <= dbn_d;
            dan_q   <= dan_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_dbn   = dbn_q;
    assign rsp_dan   = dan_q;
    assign rsp_error = err_q;

endmodule

// File: tb/tb_date_offset_sched.sv
// Bench for date_offset_sched: per-cycle reference model using modular day
// arithmetic, directed calendar cases, arbitration, backpressure and reset.
module tb_date_offset_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_day30_31;
    logic [4:0] req0_today;
    logic [2:0] req0_n;
    logic       req1_valid, req1_ready, req1_day30_31;
    logic [4:0] req1_today;
    logic [2:0] req1_n;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_error, busy;
    logic [4:0] rsp_dbn, rsp_dan;

    date_offset_sched #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_today(req0_today),
        .req0_day30_31(req0_day30_31), .req0_n(req0_n),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_today(req1_today),
        .req1_day30_31(req1_day30_31), .req1_n(req1_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_dbn(rsp_dbn), .rsp_dan(rsp_dan), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle time %0t)", tag, got, exp, $time);
        end
    endtask

    // Requester stimulus held until accepted
    bit         pend [2];
    logic [4:0] qt   [2];
    bit         qd   [2];
    logic [2:0] qn   [2];
    int         refill   = 0;   // 0 none, 1 random, 2 fixed arbitration pair
    int         rdy_mode = 1;   // 0 low, 1 high, 2 random
    bit         rst_drv  = 1'b0;
    bit         log_ids  = 1'b0;
    bit         hs_ids[$];

    // Model state
    int unsigned cyc = 0;
    bit          inflight = 1'b0;
    bit          rr_m = 1'b0;
    int unsigned due = 0;
    bit          e_id, e_err;
    int          e_dbn, e_dan;

    task automatic model_accept(input bit id);
        int len, today, n;
        len   = qd[id] ? 31 : 30;
        today = int'(qt[id]);
        n     = int'(qn[id]);
        e_id  = id;
        e_err = (today == 0) || (today > len);
        if (e_err) begin
            e_dbn = 0;
            e_dan = 0;
            due   = cyc + 2;
        end else begin
            e_dbn = ((today - 1 - n) % len + len) % len + 1;
            e_dan = (today - 1 + n) % len + 1;
            due   = cyc + 2 + n;
        end
        inflight = 1'b1;
        rr_m     = ~id;
        pend[id] = 1'b0;
    endtask

    task automatic set_q(input bit id, input int today, input bit d31, input int n);
        pend[id] = 1'b1;
        qt[id]   = 5'(today);
        qd[id]   = d31;
        qn[id]   = 3'(n);
    endtask

    // One clock cycle: drive, check, advance model, wait for next edge
    task automatic tick();
        bit hs, g0, g1, v_exp;
        for (int r = 0; r < 2; r++) begin
            if (refill == 1 && !pend[r] && $urandom_range(0, 2) == 0)
                set_q(r[0], $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
            else if (refill == 2 && !pend[r])
                set_q(r[0], r == 0 ? 10 : 20, 1'b1, r == 0 ? 1 : 2);
        end
        req0_valid    = pend[0];
        req0_today    = pend[0] ? qt[0] : 5'($urandom);
        req0_day30_31 = pend[0] ? qd[0] : 1'($urandom);
        req0_n        = pend[0] ? qn[0] : 3'($urandom);
        req1_valid    = pend[1];
        req1_today    = pend[1] ? qt[1] : 5'($urandom);
        req1_day30_31 = pend[1] ? qd[1] : 1'($urandom);
        req1_n        = pend[1] ? qn[1] : 3'($urandom);
        rsp_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        rst = rst_drv;
        #1;
        g0 = 1'b0;
        g1 = 1'b0;
        if (inflight) begin
            v_exp = (cyc >= due);
            check("busy_inflight", busy, 1);
            check("rsp_valid", rsp_valid, v_exp);
            check("ready0_blocked", req0_ready, 0);
            check("ready1_blocked", req1_ready, 0);
            if (v_exp) begin
                check("rsp_id", rsp_id, e_id);
                check("rsp_error", rsp_error, e_err);
                check("rsp_dbn", rsp_dbn, e_dbn);
                check("rsp_dan", rsp_dan, e_dan);
            end
        end else begin
            g0 = !rst_drv && pend[0] && (!pend[1] || rr_m == 1'b0);
            g1 = !rst_drv && pend[1] && (!pend[0] || rr_m == 1'b1);
            check("busy_idle", busy, 0);
            check("rsp_valid_idle", rsp_valid, 0);
            check("req0_ready", req0_ready, g0);
            check("req1_ready", req1_ready, g1);
        end
        hs = inflight && (cyc >= due) && rsp_ready;
        if (rst_drv) begin
            inflight = 1'b0;
            rr_m     = 1'b0;
        end else if (hs) begin
            if (log_ids) hs_ids.push_back(e_id);
            inflight = 1'b0;
        end else if (g0) begin
            model_accept(1'b0);
        end else if (g1) begin
            model_accept(1'b1);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_until_idle(input int unsigned max);
        int unsigned n = 0;
        while ((inflight || pend[0] || pend[1]) && n < max) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(inflight || pend[0] || pend[1]), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_dbn"}, rsp_dbn, 0);
        check({tag, "_rsp_dan"}, rsp_dan, 0);
        check({tag, "_rsp_error"}, rsp_error, 0);
    endtask

    initial begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_today = '0; req0_day30_31 = 1'b0; req0_n = '0;
        req1_valid = 1'b0; req1_today = '0; req1_day30_31 = 1'b0; req1_n = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_ready0", req0_ready, 0);
        check("reset_ready1", req1_ready, 0);

        // Invalid days, month-start and month-end wrap
        set_q(1'b0, 31, 1'b0, 3); run_until_idle(40);
        set_q(1'b0, 0, 1'b1, 3);  run_until_idle(40);
        set_q(1'b0, 3, 1'b1, 3);  run_until_idle(40);
        set_q(1'b0, 28, 1'b0, 5); run_until_idle(40);
        set_q(1'b1, 30, 1'b0, 7); run_until_idle(40);

        // Backpressure on an N=0 query with the other requester waiting
        rdy_mode = 0;
        set_q(1'b0, 15, 1'b0, 0);
        tick();
        set_q(1'b1, 4, 1'b1, 2);
        repeat (8) tick();
        check("bp_hold_valid", rsp_valid, 1);
        check("bp_hold_dbn", rsp_dbn, 15);
        rdy_mode = 1;
        run_until_idle(40);

        // Reset in the middle of stepping an N=7 query
        set_q(1'b0, 5, 1'b1, 7);
        repeat (3) tick();
        check("midop_busy", busy, 1);
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        check_reset_outputs("midop");
        repeat (3) tick();
        set_q(1'b1, 9, 1'b0, 1);
        set_q(1'b0, 12, 1'b1, 2);
        tick();
        check("post_reset_grant_id", e_id, 0);
        run_until_idle(40);

        // Arbitration with both requesters valid every cycle from a fresh reset
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        refill  = 2;
        log_ids = 1'b1;
        for (int k = 0; k < 60 && hs_ids.size() < 4; k++) tick();
        refill  = 0;
        log_ids = 1'b0;
        run_until_idle(40);
        check("arb_count", 32'(hs_ids.size() >= 4), 1);
        for (int k = 0; k < hs_ids.size() && k < 4; k++)
            check("arb_alternate", hs_ids[k], 32'(k % 2));

        // Randomized traffic with random backpressure
        refill   = 1;
        rdy_mode = 2;
        repeat (600) tick();
        refill   = 0;
        run_until_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
